// File: rtl/button_conditioner.sv
// button_conditioner
//   Front end for the payment/vending logic. Each raw push-button goes through
//   a two-flop synchroniser and a per-button debounce counter. The result is a
//   stable level vector (bt_press) and single-cycle press pulses (bt_edge).
//   Press pulses are serialised by priority, so at most one bt_edge bit is set
//   in any cycle. The lowest index wins.
//
// Handshake: there is no back-pressure. A set bit in bt_edge is a one-cycle
//   event that the consumer must take in that cycle. bt_pending is high
//   whenever at least one more press is queued behind the current grant.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   btn_in     raw asynchronous button levels, 1 = pressed
//   bt_press   debounced stable level per button
//   bt_edge    one-cycle press pulse, zero or one bit set per cycle
//   bt_pending high while a debounced press still awaits emission on bt_edge
module button_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] bt_press,
  output logic [NUM_BTN-1:0] bt_edge,
  output logic               bt_pending
);

  // The terminal count must fit in the counter width.
  // At least two samples are needed for glitch rejection to mean anything.
  if ((DEBOUNCE_CYCLES < 2) ||
      ((longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W))) begin : g_bad_params
    $error("button_conditioner: DEBOUNCE_CYCLES-1 must fit in CNT_W bits and DEBOUNCE_CYCLES >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] pending;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  // live[1] goes high once sync2 holds a real sample of btn_in rather than
  // its reset value. Arming waits for it so that a button held through reset
  // release is not mistaken for a released one.
  logic [1:0]         live;

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] req;
  logic [NUM_BTN-1:0] grant;

  always_comb begin
    rise  = bt_press & ~press_d & armed;
    req   = pending | rise;
    // Isolate the lowest set bit. This is the fixed-priority grant.
    grant = req & (~req + NUM_BTN'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      press_d    <= '0;
      armed      <= '0;
      pending    <= '0;
      live       <= '0;
      bt_press   <= '0;
      bt_edge    <= '0;
      bt_pending <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      live    <= {live[0], 1'b1};
      press_d <= bt_press;

      for (int i = 0; i < NUM_BTN; i++) begin
        // Any sample that agrees with the stable state restarts the count.
        if (sync2[i] == bt_press[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          bt_press[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end

        // Arming is sticky. Only reset clears it.
        if (live[1] && !bt_press[i] && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
      end

      bt_edge    <= grant;
      pending    <= req & ~grant;
      bt_pending <= |(req & ~grant);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE_CYCLES=4 and CNT_W=3.
// Directed stimulus pushes the expected press pulses into exp_q, each with
// the tb cycle at which it must appear in exp_t. A monitor pops and compares
// every non-zero bt_edge. Level outputs are checked inline by the stimulus.
module tb_button_conditioner;
  localparam int NUM_BTN = 5;
  localparam int DEB     = 4;
  localparam int CW      = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_BTN-1:0] btn_in = '0;
  logic [NUM_BTN-1:0] bt_press;
  logic [NUM_BTN-1:0] bt_edge;
  logic               bt_pending;

  button_conditioner #(
    .NUM_BTN(NUM_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .bt_press(bt_press),
    .bt_edge(bt_edge),
    .bt_pending(bt_pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Count of posedges seen. In the cycle following edge k, counted from a
  // stimulus change at cycle N, cyc equals N+1+k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [NUM_BTN-1:0] exp_q[$];
  int                 exp_t[$];
  int                 n_checks = 0;
  int                 n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [NUM_BTN-1:0] act,
                       input logic [NUM_BTN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_edge(input logic [NUM_BTN-1:0] v, input int t);
    exp_q.push_back(v);
    exp_t.push_back(t);
  endtask

  int n0;
  logic [NUM_BTN-1:0] ev;
  int et;
  bit bounce [7];

  initial begin
    bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Monitor: compares every presented press pulse against the queue head.
    fork
      forever begin
        @(negedge clk);
        if (!rst && bt_edge != '0) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL edge_unexpected: got %b at cycle %0d, required none", bt_edge, cyc);
          end else begin
            ev = exp_q.pop_front();
            et = exp_t.pop_front();
            if (bt_edge !== ev || cyc != et) begin
              n_errors++;
              $display("FAIL edge_pulse: got %b at cycle %0d, required %b at cycle %0d",
                       bt_edge, cyc, ev, et);
            end
          end
        end
      end
    join_none

    // ---- reset state ----
    tick(3);
    check("reset_press", bt_press, '0);
    check("reset_edge", bt_edge, '0);
    check("reset_pending", {4'b0, bt_pending}, '0);
    rst = 1'b0;
    tick(5);

    // ---- single press on bit 2, then release ----
    n0 = cyc;
    btn_in = 5'b00100;
    expect_edge(5'b00100, n0 + 7);
    tick(5);
    check("press2_edge4", bt_press, 5'b00000);
    tick(1);
    check("press2_edge5", bt_press, 5'b00100);
    tick(6);
    check("press2_held", bt_press, 5'b00100);
    btn_in = 5'b00000;
    tick(5);
    check("release2_edge4", bt_press, 5'b00100);
    tick(1);
    check("release2_edge5", bt_press, 5'b00000);
    tick(4);

    // ---- glitch: three high samples are rejected ----
    btn_in = 5'b00001;
    tick(3);
    btn_in = 5'b00000;
    tick(10);
    check("glitch_press", bt_press, 5'b00000);

    // ---- bounce 1,1,0,1,1,1,1 on bit 0 ----
    n0 = cyc;
    foreach (bounce[i]) begin
      btn_in[0] = bounce[i];
      tick(1);
    end
    expect_edge(5'b00001, n0 + 10);
    tick(1);
    check("bounce_edge7", bt_press, 5'b00000);
    tick(1);
    check("bounce_edge8", bt_press, 5'b00001);
    tick(3);
    btn_in = 5'b00000;
    tick(8);
    check("bounce_released", bt_press, 5'b00000);

    // ---- simultaneous rise on bits 4, 1, 0 ----
    n0 = cyc;
    btn_in = 5'b10011;
    expect_edge(5'b00001, n0 + 7);
    expect_edge(5'b00010, n0 + 8);
    expect_edge(5'b10000, n0 + 9);
    tick(6);
    check("simul_pend_edge5", {4'b0, bt_pending}, 5'b0);
    check("simul_press", bt_press, 5'b10011);
    tick(1);
    check("simul_pend_edge6", {4'b0, bt_pending}, 5'b1);
    tick(1);
    check("simul_pend_edge7", {4'b0, bt_pending}, 5'b1);
    tick(1);
    check("simul_pend_edge8", {4'b0, bt_pending}, 5'b0);
    tick(2);
    // Release only bit 1. This must not produce a pulse.
    btn_in = 5'b10001;
    tick(5);
    check("release1_edge4", bt_press, 5'b10011);
    tick(1);
    check("release1_edge5", bt_press, 5'b10001);
    btn_in = 5'b00000;
    tick(8);
    check("simul_released", bt_press, 5'b00000);

    // ---- reset while pulses are still queued ----
    n0 = cyc;
    btn_in = 5'b10011;
    expect_edge(5'b00001, n0 + 7);
    tick(7);
    check("midrst_press_before", bt_press, 5'b10011);
    check("midrst_pend_before", {4'b0, bt_pending}, 5'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_press", bt_press, 5'b00000);
    check("midrst_edge", bt_edge, 5'b00000);
    check("midrst_pend", {4'b0, bt_pending}, 5'b0);
    btn_in = 5'b00000;
    tick(2);
    rst = 1'b0;
    tick(12);
    check("midrst_after_press", bt_press, 5'b00000);
    check("midrst_after_pend", {4'b0, bt_pending}, 5'b0);

    // ---- button held through reset release ----
    rst = 1'b1;
    btn_in = 5'b01000;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("held_edge4", bt_press, 5'b00000);
    tick(1);
    check("held_edge5", bt_press, 5'b01000);
    tick(6);
    btn_in = 5'b00000;
    tick(8);
    check("held_released", bt_press, 5'b00000);
    n0 = cyc;
    btn_in = 5'b01000;
    expect_edge(5'b01000, n0 + 7);
    tick(10);
    check("held_repress", bt_press, 5'b01000);
    btn_in = 5'b00000;
    tick(8);

    // ---- final report ----
    while (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      ev = exp_q.pop_front();
      et = exp_t.pop_front();
      $display("FAIL edge_missing: got no pulse, required %b at cycle %0d", ev, et);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
